// File: rtl/gpu_frame_buffer_ctrl.sv
// Frame-buffer RAM: byte-enabled render port A, read-only scanout port B,
// and a one-word-per-cycle fast-clear engine that shares port A's write path.
module gpu_frame_buffer_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 19,
  parameter int DEPTH   = 480000,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address_a,
  input  logic [DATA_W/8-1:0] byteenable_a,
  input  logic                read_a,
  input  logic                write_a,
  input  logic [DATA_W-1:0]   writedata_a,
  output logic                waitrequest_a,
  output logic [DATA_W-1:0]   readdata_a,
  output logic                readdatavalid_a,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic                read_b,
  output logic [DATA_W-1:0]   readdata_b,
  output logic                readdatavalid_b,
  input  logic                clear_req,
  input  logic [DATA_W-1:0]   clear_value,
  output logic                clear_busy,
  output logic                clear_done
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_clr_val, w_clr_val_nxt;
  logic                r_done, w_done_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_inr_a, w_inr_b, w_acc_a, w_wr_a, w_rd_a;
  logic [IDX_W-1:0]    w_idx_a, w_idx_b;
  logic                r_v1_a, r_v1_b;
  logic [DATA_W-1:0]   r_d1_a, r_d1_b;

  assign clear_busy    = (r_state == S_CLEAR);
  assign clear_done    = r_done;
  assign waitrequest_a = clear_busy | clear_req;

  // Address bits above IDX_W only matter for the range check.
  assign w_inr_a = {1'b0, address_a} < DEPTH_L;
  assign w_inr_b = {1'b0, address_b} < DEPTH_L;
  assign w_idx_a = address_a[IDX_W-1:0];
  assign w_idx_b = address_b[IDX_W-1:0];
  assign w_acc_a = (read_a | write_a) & ~waitrequest_a;
  assign w_wr_a  = w_acc_a & write_a & w_inr_a;
  assign w_rd_a  = w_acc_a & read_a & ~write_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clr_val <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_val <= w_clr_val_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clr_val_nxt = r_clr_val;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: if (clear_req) begin
        w_state_nxt   = S_CLEAR;
        w_cnt_nxt     = '0;
        w_clr_val_nxt = clear_value;
      end
      S_CLEAR: if (r_cnt == LAST) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clear owns the port-A write path while busy; port A is stalled then anyway.
  always_ff @(posedge clk) begin
    if (clear_busy)
      r_mem[r_cnt[IDX_W-1:0]] <= r_clr_val;
    else if (w_wr_a)
      for (int i = 0; i < BE_W; i++)
        if (byteenable_a[i]) r_mem[w_idx_a][8*i +: 8] <= writedata_a[8*i +: 8];
  end

  // First read stage; data registers only load on a read so they hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1_a <= 1'b0;
      r_v1_b <= 1'b0;
      r_d1_a <= '0;
      r_d1_b <= '0;
    end else begin
      r_v1_a <= w_rd_a;
      r_v1_b <= read_b;
      if (w_rd_a) r_d1_a <= w_inr_a ? r_mem[w_idx_a] : '0;
      if (read_b) r_d1_b <= w_inr_b ? r_mem[w_idx_b] : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_v2_a, r_v2_b;
      logic [DATA_W-1:0] r_d2_a, r_d2_b;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2_a <= 1'b0;
          r_v2_b <= 1'b0;
          r_d2_a <= '0;
          r_d2_b <= '0;
        end else begin
          r_v2_a <= r_v1_a;
          r_v2_b <= r_v1_b;
          if (r_v1_a) r_d2_a <= r_d1_a;
          if (r_v1_b) r_d2_b <= r_d1_b;
        end
      end
      assign readdata_a      = r_d2_a;
      assign readdatavalid_a = r_v2_a;
      assign readdata_b      = r_d2_b;
      assign readdatavalid_b = r_v2_b;
    end else begin : g_noreg
      assign readdata_a      = r_d1_a;
      assign readdatavalid_a = r_v1_a;
      assign readdata_b      = r_d1_b;
      assign readdatavalid_b = r_v1_b;
    end
  endgenerate
endmodule

// File: tb/tb_gpu_frame_buffer_ctrl.sv
// Scoreboarded bench: dut0 (latency 1) and dut1 (OUT_REG=1, latency 2), both DEPTH=16.
module tb_gpu_frame_buffer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  addr_a [2], addr_b [2];
  logic [3:0]  be_a [2];
  logic        rd_a [2], wr_a [2], rd_b [2], clr_req [2];
  logic        wait_a [2], rvld_a [2], rvld_b [2], busy [2], done [2];
  logic [31:0] wd_a [2], rdata_a [2], rdata_b [2], clr_val [2];

  gpu_frame_buffer_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .OUT_REG(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .address_a(addr_a[0]), .byteenable_a(be_a[0]),
    .read_a(rd_a[0]), .write_a(wr_a[0]), .writedata_a(wd_a[0]), .waitrequest_a(wait_a[0]),
    .readdata_a(rdata_a[0]), .readdatavalid_a(rvld_a[0]), .address_b(addr_b[0]),
    .read_b(rd_b[0]), .readdata_b(rdata_b[0]), .readdatavalid_b(rvld_b[0]),
    .clear_req(clr_req[0]), .clear_value(clr_val[0]), .clear_busy(busy[0]), .clear_done(done[0]));

  gpu_frame_buffer_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .OUT_REG(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .address_a(addr_a[1]), .byteenable_a(be_a[1]),
    .read_a(rd_a[1]), .write_a(wr_a[1]), .writedata_a(wd_a[1]), .waitrequest_a(wait_a[1]),
    .readdata_a(rdata_a[1]), .readdatavalid_a(rvld_a[1]), .address_b(addr_b[1]),
    .read_b(rd_b[1]), .readdata_b(rdata_b[1]), .readdatavalid_b(rvld_b[1]),
    .clear_req(clr_req[1]), .clear_value(clr_val[1]), .clear_busy(busy[1]), .clear_done(done[1]));

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t qa0[$], qb0[$], qa1[$], qb1[$];
  exp_t dummy = '{32'h0, 0};
  int n_chk = 0, n_fail = 0;
  int wcnt = 0, dcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compares one stream per call; pop tells the caller to drop the queue head.
  task automatic mon(input string nm, input logic v, input logic [31:0] d,
                     input int qs, input exp_t f, output logic pop);
    pop = 1'b0;
    if (v) begin
      if (qs == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s_unexpected: got valid data %h expected no valid (cycle %0d)", nm, d, cyc);
      end else begin
        pop = 1'b1;
        chk({nm, "_data"}, d, f.d);
        chk({nm, "_cycle"}, cyc, f.c);
      end
    end else if (qs > 0 && f.c < cyc) begin
      pop = 1'b1;
      n_chk++; n_fail++;
      $display("FAIL %s_missing: got no valid expected valid at cycle %0d data %h", nm, f.c, f.d);
    end
  endtask

  always @(negedge clk) begin
    logic p;
    #1;
    mon("a0", rvld_a[0], rdata_a[0], qa0.size(), (qa0.size() > 0) ? qa0[0] : dummy, p);
    if (p) void'(qa0.pop_front());
    mon("b0", rvld_b[0], rdata_b[0], qb0.size(), (qb0.size() > 0) ? qb0[0] : dummy, p);
    if (p) void'(qb0.pop_front());
    mon("a1", rvld_a[1], rdata_a[1], qa1.size(), (qa1.size() > 0) ? qa1[0] : dummy, p);
    if (p) void'(qa1.pop_front());
    mon("b1", rvld_b[1], rdata_b[1], qb1.size(), (qb1.size() > 0) ? qb1[0] : dummy, p);
    if (p) void'(qb1.pop_front());
  end

  always @(negedge clk) begin
    #2;
    if (wait_a[0]) wcnt++;
    if (done[0]) dcnt++;
  end

  // Driver tasks are entered at a negedge and return at the next one.
  task automatic wr(input int d, input logic [4:0] a, input logic [31:0] v, input logic [3:0] be);
    addr_a[d] = a; wd_a[d] = v; be_a[d] = be; wr_a[d] = 1'b1;
    @(negedge clk);
    wr_a[d] = 1'b0;
  endtask

  task automatic rda(input int d, input logic [4:0] a, input logic [31:0] e);
    exp_t x;
    x.d = e; x.c = cyc + 1 + d;
    if (d == 0) qa0.push_back(x); else qa1.push_back(x);
    addr_a[d] = a; rd_a[d] = 1'b1;
    @(negedge clk);
    rd_a[d] = 1'b0;
  endtask

  task automatic rdb(input int d, input logic [4:0] a, input logic [31:0] e);
    exp_t x;
    x.d = e; x.c = cyc + 1 + d;
    if (d == 0) qb0.push_back(x); else qb1.push_back(x);
    addr_b[d] = a; rd_b[d] = 1'b1;
    @(negedge clk);
    rd_b[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr_a[d] = '0; addr_b[d] = '0; be_a[d] = '0; rd_a[d] = 0; wr_a[d] = 0;
      rd_b[d] = 0; clr_req[d] = 0; wd_a[d] = '0; clr_val[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata_a", rdata_a[d], 0);
      chk("rst_rvld_a", {31'b0, rvld_a[d]}, 0);
      chk("rst_rdata_b", rdata_b[d], 0);
      chk("rst_rvld_b", {31'b0, rvld_b[d]}, 0);
      chk("rst_busy", {31'b0, busy[d]}, 0);
      chk("rst_done", {31'b0, done[d]}, 0);
      chk("rst_wait", {31'b0, wait_a[d]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read, byte lanes, empty byte-enable, out-of-range reads
    wr(0, 3, 32'hDEADBEEF, 4'hF);
    rda(0, 3, 32'hDEADBEEF);
    wr(0, 5, 32'h11223344, 4'hF);
    wr(0, 5, 32'hAABBCCDD, 4'b0101);
    rda(0, 5, 32'h11BB33DD);
    wr(0, 5, 32'hFFFFFFFF, 4'h0);
    rda(0, 5, 32'h11BB33DD);
    rdb(0, 20, 32'h0);
    rda(0, 20, 32'h0);
    repeat (2) @(negedge clk);

    // Clear with B streaming the same address being cleared each cycle
    for (int k = 0; k < 16; k++) wr(0, 5'(k), 32'h1000_0000 + k, 4'hF);
    wcnt = 0; dcnt = 0;
    clr_val[0] = 32'h00FF00FF; clr_req[0] = 1'b1;
    @(negedge clk);
    clr_req[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clr_req[0] = (k == 8);
      if (k == 8) clr_val[0] = 32'hBAD0BAD0;
      wr_a[0] = (k == 3);
      addr_a[0] = 5'd2; wd_a[0] = 32'h0BAD0BAD; be_a[0] = 4'hF;
      rdb(0, 5'(k), 32'h1000_0000 + k);
    end
    clr_req[0] = 1'b0; wr_a[0] = 1'b0;
    chk("clr_busy_fall", {31'b0, busy[0]}, 0);
    chk("clr_done_on", {31'b0, done[0]}, 1);
    repeat (3) @(negedge clk);
    chk("clr_wait_cycles", wcnt, 17);
    chk("clr_done_pulses", dcnt, 1);
    for (int k = 0; k < 16; k++) rdb(0, 5'(k), 32'h00FF00FF);
    rda(0, 2, 32'h00FF00FF);

    // Latency-2 instance: back-to-back reads, out-of-range read/write, hold
    wr(1, 0, 32'hA0A0A0A0, 4'hF);
    wr(1, 1, 32'hA1A1A1A1, 4'hF);
    wr(1, 2, 32'hA2A2A2A2, 4'hF);
    wr(1, 4, 32'h44444444, 4'hF);
    rda(1, 0, 32'hA0A0A0A0);
    rda(1, 1, 32'hA1A1A1A1);
    rda(1, 2, 32'hA2A2A2A2);
    rda(1, 20, 32'h0);
    wr(1, 20, 32'hDEADDEAD, 4'hF);
    rda(1, 4, 32'h44444444);
    rdb(1, 4, 32'h44444444);
    rdb(1, 20, 32'h0);
    repeat (4) @(negedge clk);
    chk("hold_a1", rdata_a[1], 32'h44444444);
    chk("hold_b1", rdata_b[1], 32'h0);

    // Reset during clear at word 6; an in-flight B read must vanish
    for (int k = 0; k < 16; k++) wr(0, 5'(k), 32'hA000_0000 + k, 4'hF);
    dcnt = 0;
    clr_val[0] = 32'h55555555; clr_req[0] = 1'b1;
    @(negedge clk);
    clr_req[0] = 1'b0;
    repeat (5) @(negedge clk);
    addr_b[0] = 5'd9; rd_b[0] = 1'b1;
    @(negedge clk);
    rd_b[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy[0]}, 0);
    chk("abort_wait", {31'b0, wait_a[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", dcnt, 0);
    for (int k = 0; k < 16; k++)
      rdb(0, 5'(k), (k < 6) ? 32'h55555555 : 32'hA000_0000 + k);

    repeat (4) @(negedge clk);
    chk("qa0_drained", qa0.size(), 0);
    chk("qb0_drained", qb0.size(), 0);
    chk("qa1_drained", qa1.size(), 0);
    chk("qb1_drained", qb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
